// File: rtl/ahblite_led_sequencer.sv
// AHB-Lite LED pattern sequencer.
// Four LED patterns are stepped through with a programmable step length. The
// sequence either loops or stops on the last step, with no CPU involvement
// once it has been started.
// Optional build macro: LED_SEQ_PWM_EN adds a 4-bit brightness register at
// 0x0C and a period-15 PWM gate on the LED output.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | sequencer stopped, LED driven to 0
// RUN     | stepping through PATTERN0..LAST, each step PRESCALE+1 cycles
// DONE    | one-shot finished, LED holds PATTERN[LAST] until a CTRL write

module ahblite_led_sequencer #(
  parameter int LED_W      = 8,
  parameter int PRESCALE_W = 24
) (
  input  logic             HCLK,
  input  logic             HRESET,
  input  logic             HSEL,
  input  logic [31:0]      HADDR,
  input  logic [1:0]       HTRANS,
  input  logic [2:0]       HSIZE,
  input  logic [3:0]       HPROT,
  input  logic             HWRITE,
  input  logic [31:0]      HWDATA,
  input  logic             HREADY,
  output logic             HREADYOUT,
  output logic [31:0]      HRDATA,
  output logic             HRESP,
  output logic [LED_W-1:0] LED
);

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_RUN  = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;

  localparam logic [2:0] A_CTRL     = 3'd0;
  localparam logic [2:0] A_PRESCALE = 3'd1;
  localparam logic [2:0] A_STATUS   = 3'd2;
  localparam logic [2:0] A_BRIGHT   = 3'd3;

  // Bus data-phase tracking
  logic       act_q, act_d;
  logic       wr_q, wr_d;
  logic [2:0] addr_q, addr_d;
  logic       oow_q, oow_d;

  // Register file
  logic [3:0]            ctrl_q, ctrl_d;
  logic [PRESCALE_W-1:0] prescale_q, prescale_d;
  logic [LED_W-1:0]      pat_q [4];
  logic [LED_W-1:0]      pat_d [4];

  // Sequencer
  logic [1:0]            state_q, state_d;
  logic [1:0]            idx_q, idx_d;
  logic [PRESCALE_W-1:0] count_q, count_d;
  logic [LED_W-1:0]      led_q, led_d;
  logic [LED_W-1:0]      led_norm;

`ifdef LED_SEQ_PWM_EN
  logic [3:0] bright_q, bright_d;
  logic [3:0] pwm_q, pwm_d;
`endif

  logic wr_en;
  logic ctrl_wr;
  logic ctrl_en;
  logic ctrl_oneshot;
  logic [1:0] ctrl_last;

  // Size/protection are ignored and only a few address/data bits are used;
  // fold the rest here so they are visibly consumed.
  logic unused_inputs;
  assign unused_inputs = ^{HSIZE, HPROT, HADDR, HWDATA};

  assign HREADYOUT = 1'b1;
  assign HRESP     = 1'b0;
  assign LED       = led_q;

  assign ctrl_en      = ctrl_q[0];
  assign ctrl_oneshot = ctrl_q[1];
  assign ctrl_last    = ctrl_q[3:2];

  // A write commits on the data-phase edge; offsets 0x20-0x3F are outside the
  // register window so they never alias onto a real register.
  assign wr_en   = act_q & wr_q & ~oow_q;
  assign ctrl_wr = wr_en & (addr_q == A_CTRL);

  // Capture the address phase of each accepted transfer
  always_comb begin
    act_d  = HSEL & HTRANS[1] & HREADY;
    wr_d   = wr_q;
    addr_d = addr_q;
    oow_d  = oow_q;
    if (act_d) begin
      wr_d   = HWRITE;
      addr_d = HADDR[4:2];
      oow_d  = HADDR[5];
    end
  end

  // Register writes from the data phase
  always_comb begin
    ctrl_d     = ctrl_q;
    prescale_d = prescale_q;
    pat_d      = pat_q;
`ifdef LED_SEQ_PWM_EN
    bright_d   = bright_q;
`endif
    if (wr_en) begin
      case (addr_q)
        A_CTRL:     ctrl_d     = HWDATA[3:0];
        A_PRESCALE: prescale_d = HWDATA[PRESCALE_W-1:0];
`ifdef LED_SEQ_PWM_EN
        A_BRIGHT:   bright_d   = HWDATA[3:0];
`endif
        3'd4, 3'd5, 3'd6, 3'd7: pat_d[addr_q[1:0]] = HWDATA[LED_W-1:0];
        default: ;
      endcase
    end
  end

  // Zero-wait read mux driven from the registered address
  always_comb begin
    HRDATA = 32'h0;
    if (!oow_q) begin
      case (addr_q)
        A_CTRL:     HRDATA = {28'h0, ctrl_q};
        A_PRESCALE: HRDATA = 32'(prescale_q);
        A_STATUS:   HRDATA = {28'h0, (state_q == ST_DONE), idx_q, (state_q == ST_RUN)};
`ifdef LED_SEQ_PWM_EN
        A_BRIGHT:   HRDATA = {28'h0, bright_q};
`endif
        3'd4, 3'd5, 3'd6, 3'd7: HRDATA = 32'(pat_q[addr_q[1:0]]);
        default: HRDATA = 32'h0;
      endcase
    end
  end

  // Sequencer next state; a CTRL write overrides any step event that cycle
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    count_d = count_q;
    if (ctrl_wr) begin
      idx_d = 2'd0;
      if (HWDATA[0]) begin
        state_d = ST_RUN;
        count_d = prescale_q;
      end else begin
        state_d = ST_IDLE;
        count_d = '0;
      end
    end else begin
      case (state_q)
        ST_RUN: begin
          if (count_q != '0) begin
            count_d = count_q - PRESCALE_W'(1);
          end else if (idx_q != ctrl_last) begin
            idx_d   = idx_q + 2'd1;
            count_d = prescale_q;
          end else if (!ctrl_oneshot) begin
            idx_d   = 2'd0;
            count_d = prescale_q;
          end else begin
            state_d = ST_DONE;
          end
        end
        ST_IDLE: ;
        ST_DONE: ;
        default: begin
          state_d = ST_IDLE;
          idx_d   = 2'd0;
          count_d = '0;
        end
      endcase
    end
  end

  // LED next value from the current step, optionally brightness-gated
  always_comb begin
    led_norm = (state_q == ST_IDLE) ? '0 : pat_q[idx_q];
`ifdef LED_SEQ_PWM_EN
    pwm_d = (pwm_q == 4'd14) ? 4'd0 : pwm_q + 4'd1;
    led_d = (pwm_q < bright_q) ? led_norm : '0;
`else
    led_d = led_norm;
`endif
  end

  // All state, synchronous active-high reset
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      act_q      <= 1'b0;
      wr_q       <= 1'b0;
      addr_q     <= 3'd0;
      oow_q      <= 1'b0;
      ctrl_q     <= 4'd0;
      prescale_q <= '0;
      pat_q      <= '{default: '0};
      state_q    <= ST_IDLE;
      idx_q      <= 2'd0;
      count_q    <= '0;
      led_q      <= '0;
`ifdef LED_SEQ_PWM_EN
      bright_q   <= 4'hF;
      pwm_q      <= 4'd0;
`endif
    end else begin
      act_q      <= act_d;
      wr_q       <= wr_d;
      addr_q     <= addr_d;
      oow_q      <= oow_d;
      ctrl_q     <= ctrl_d;
      prescale_q <= prescale_d;
      pat_q      <= pat_d;
      state_q    <= state_d;
      idx_q      <= idx_d;
      count_q    <= count_d;
      led_q      <= led_d;
`ifdef LED_SEQ_PWM_EN
      bright_q   <= bright_d;
      pwm_q      <= pwm_d;
`endif
    end
  end

endmodule
